// File: rtl/lsu_mem_master.sv
// Load/store unit for a word-wide data memory with one-cycle read latency.
// Handles RV32I load extension and turns sub-word stores into read-modify-write.
module lsu_mem_master #(
    parameter int MEM_WORDS = 4096,
    parameter int XLEN      = 32    // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,

    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,

    output logic [XLEN-1:0] mem_addr,
    output logic            mem_r_enable,
    output logic            mem_w_enable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [XLEN-1:0] addr_q;
    logic [2:0]      funct3_q;
    logic            we_q;
    logic [XLEN-1:0] wbuf;

    logic            accept;
    logic            req_illegal;
    logic            req_misaligned;
    logic            req_oor;
    logic            req_err;

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] word,
        input logic [1:0]      lane,
        input logic [2:0]      f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    return {{(XLEN-8){b[7]}}, b};
            F3_BU:   return {{(XLEN-8){1'b0}}, b};
            F3_H:    return {{(XLEN-16){h[15]}}, h};
            F3_HU:   return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    // Overlay the store data onto the word just read back from memory.
    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0] word,
        input logic [1:0]      lane,
        input logic [2:0]      f3,
        input logic [XLEN-1:0] data
    );
        logic [XLEN-1:0] m;
        m = word;
        case (f3[1:0])
            2'b00:   m[{lane, 3'b000} +: 8]     = data[7:0];
            2'b01:   m[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: m = data;
        endcase
        return m;
    endfunction

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        if (req_we) begin
            req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_oor        = {1'b0, req_addr} >= MEM_BYTES;
        req_err        = req_illegal || req_misaligned || req_oor;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nx = S_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_nx = S_WR;
                    end else begin
                        state_nx = S_RD;
                    end
                end
            end
            S_RD:      state_nx = S_RD_WAIT;
            S_RD_WAIT: state_nx = we_q ? S_WR : S_RESP;
            S_WR:      state_nx = S_RESP;
            S_RESP:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Memory strobes come straight from the registered state.
    assign mem_r_enable = (state == S_RD);
    assign mem_w_enable = (state == S_WR);
    assign mem_wdata    = (state == S_WR) ? wbuf : '0;
    assign resp_valid   = (state == S_RESP);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            wbuf       <= '0;
            mem_addr   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;

            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                we_q     <= req_we;
                wbuf     <= req_wdata;
                // Faulting requests never touch memory, so the bus address is left alone.
                if (!req_err) begin
                    mem_addr <= {req_addr[XLEN-1:2], 2'b00};
                end
            end

            if ((state == S_RD_WAIT) && we_q) begin
                wbuf <= store_merge(mem_rdata, addr_q[1:0], funct3_q, wbuf);
            end

            // Response fields change only on entry to RESP and hold until the next one.
            if (state_nx == S_RESP) begin
                resp_err <= (state == S_IDLE) && req_err;
                if ((state == S_RD_WAIT) && !we_q) begin
                    resp_rdata <= load_extract(mem_rdata, addr_q[1:0], funct3_q);
                end else begin
                    resp_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table for single requests plus
// hand-written reset and back-to-back sequences against a simple word memory.
module tb_lsu_mem_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    lsu_mem_master #(.MEM_WORDS(4096), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: read data appears the cycle after mem_r_enable.
    always @(posedge clk) begin
        if (mem_w_enable) mem[mem_addr[13:2]] <= mem_wdata;
        if (mem_r_enable) mem_rdata <= mem[mem_addr[13:2]];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre_val;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          n_rd;
        int          n_wr;
        logic        mem_chk;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(
        input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
        input logic pre_en, input logic [31:0] pre_val, input int lat, input logic [31:0] rdata,
        input logic err, input int n_rd, input int n_wr, input logic mem_chk, input logic [31:0] exp_mem
    );
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.pre_en = pre_en; v.pre_val = pre_val; v.lat = lat; v.rdata = rdata;
        v.err = err; v.n_rd = n_rd; v.n_wr = n_wr; v.mem_chk = mem_chk; v.exp_mem = exp_mem;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          k;
        int          waits;
        int          n_rd;
        int          n_wr;
        logic [31:0] wr_word;
        if (v.pre_en) begin
            mem[v.addr[13:2]] <= v.pre_val;
            tick();
        end
        waits = 0;
        while (!req_ready && waits < 20) begin
            tick();
            waits++;
        end
        check($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        tick();
        req_valid = 1'b0;
        n_rd = 0;
        n_wr = 0;
        wr_word = '0;
        for (k = 1; k <= 10; k++) begin
            if (mem_r_enable) n_rd++;
            if (mem_w_enable) begin
                n_wr++;
                wr_word = mem_wdata;
            end
            if (mem_r_enable || mem_w_enable)
                check($sformatf("v%0d_mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
            if (resp_valid) break;
            tick();
        end
        check($sformatf("v%0d_latency", idx), 32'(k), 32'(v.lat));
        check($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
        check($sformatf("v%0d_err", idx), {31'b0, resp_err}, {31'b0, v.err});
        check($sformatf("v%0d_rd_pulses", idx), 32'(n_rd), 32'(v.n_rd));
        check($sformatf("v%0d_wr_pulses", idx), 32'(n_wr), 32'(v.n_wr));
        if (v.n_wr > 0) check($sformatf("v%0d_wdata", idx), wr_word, v.exp_mem);
        tick();
        check($sformatf("v%0d_resp_drop", idx), {31'b0, resp_valid}, 32'd0);
        check($sformatf("v%0d_rdata_hold", idx), resp_rdata, v.rdata);
        check($sformatf("v%0d_idle_ready", idx), {31'b0, req_ready}, 32'd1);
        if (v.mem_chk) check($sformatf("v%0d_mem", idx), mem[v.addr[13:2]], v.exp_mem);
    endtask

    // Back-to-back traffic: alternating stores and loads with req_valid held high.
    logic        op_we    [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] op_addr  [7] = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h504, 32'h504, 32'h500};
    logic [31:0] op_wdata [7] = '{32'h11223344, 32'h0, 32'h55667788, 32'h0, 32'h99AABBCC, 32'h0, 32'h0};
    logic [31:0] op_exp   [7] = '{32'h0, 32'h11223344, 32'h0, 32'h55667788, 32'h0, 32'h99AABBCC, 32'h55667788};

    initial begin
        int n_bad;
        int acc;
        int rsp;
        int n_rd;
        int n_wr;
        logic rdy;

        vecs[0]  = mk(0, 3'b000, 32'h40F,  32'h0,        1, 32'hFF0F0E0D, 3, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0);
        vecs[1]  = mk(0, 3'b100, 32'h40F,  32'h0,        0, 32'h0,        3, 32'h000000FF, 0, 1, 0, 0, 32'h0);
        vecs[2]  = mk(0, 3'b001, 32'h40E,  32'h0,        0, 32'h0,        3, 32'hFFFFFF0F, 0, 1, 0, 0, 32'h0);
        vecs[3]  = mk(0, 3'b101, 32'h40C,  32'h0,        0, 32'h0,        3, 32'h00000E0D, 0, 1, 0, 0, 32'h0);
        vecs[4]  = mk(0, 3'b010, 32'h40C,  32'h0,        0, 32'h0,        3, 32'hFF0F0E0D, 0, 1, 0, 0, 32'h0);
        vecs[5]  = mk(1, 3'b000, 32'h401,  32'h123456AA, 1, 32'h04030201, 4, 32'h0,        0, 1, 1, 1, 32'h0403AA01);
        vecs[6]  = mk(0, 3'b000, 32'h401,  32'h0,        0, 32'h0,        3, 32'hFFFFFFAA, 0, 1, 0, 0, 32'h0);
        vecs[7]  = mk(1, 3'b001, 32'h402,  32'h0000BEEF, 1, 32'h04030201, 4, 32'h0,        0, 1, 1, 1, 32'hBEEF0201);
        vecs[8]  = mk(1, 3'b010, 32'h404,  32'hDEADBEEF, 1, 32'h11111111, 2, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF);
        vecs[9]  = mk(1, 3'b010, 32'h402,  32'hCAFEBABE, 0, 32'h0,        1, 32'h0,        1, 0, 0, 1, 32'hBEEF0201);
        vecs[10] = mk(0, 3'b001, 32'h401,  32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0);
        vecs[11] = mk(0, 3'b010, 32'h4000, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0);
        vecs[12] = mk(0, 3'b011, 32'h400,  32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0);
        vecs[13] = mk(1, 3'b100, 32'h400,  32'h77777777, 0, 32'h0,        1, 32'h0,        1, 0, 0, 1, 32'hBEEF0201);
        vecs[14] = mk(0, 3'b010, 32'h3FFC, 32'h0,        1, 32'hCAFEF00D, 3, 32'hCAFEF00D, 0, 1, 0, 0, 32'h0);
        vecs[15] = mk(0, 3'b000, 32'h3FFF, 32'h0,        0, 32'h0,        3, 32'hFFFFFFCA, 0, 1, 0, 0, 32'h0);
        vecs[16] = mk(0, 3'b100, 32'h4000, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0);
        vecs[17] = mk(0, 3'b110, 32'h400,  32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0);

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) tick();

        check("rst_ready",      {31'b0, req_ready},    32'd0);
        check("rst_resp_valid", {31'b0, resp_valid},   32'd0);
        check("rst_resp_err",   {31'b0, resp_err},     32'd0);
        check("rst_resp_rdata", resp_rdata,            32'd0);
        check("rst_mem_addr",   mem_addr,              32'd0);
        check("rst_mem_wdata",  mem_wdata,             32'd0);
        check("rst_mem_r",      {31'b0, mem_r_enable}, 32'd0);
        check("rst_mem_w",      {31'b0, mem_w_enable}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset during RD_WAIT of an SB: the write must be abandoned.
        mem[12'h100] <= 32'h04030201;
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h401; req_wdata = 32'h123456AA;
        tick();
        req_valid = 1'b0;
        check("abort_rd", {31'b0, mem_r_enable}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("abort_mem_w",  {31'b0, mem_w_enable}, 32'd0);
        check("abort_resp",   {31'b0, resp_valid},   32'd0);
        check("abort_ready_in_rst", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_w_enable || resp_valid || mem_r_enable) n_bad++;
            tick();
        end
        check("abort_quiet", 32'(n_bad), 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_mem",   mem[12'h100], 32'h04030201);

        // Request presented while reset is high must not be accepted.
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40C;
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_r_enable || resp_valid) n_bad++;
            tick();
        end
        check("rst_req_ignored", 32'(n_bad), 32'd0);
        check("rst_req_ready",   {31'b0, req_ready}, 32'd1);

        // Back-to-back stream with req_valid held high.
        acc = 0; rsp = 0; n_rd = 0; n_wr = 0;
        for (int cyc = 0; cyc < 200 && rsp < 7; cyc++) begin
            if (acc < 7) begin
                req_valid = 1'b1; req_we = op_we[acc];
                req_funct3 = 3'b010; req_addr = op_addr[acc]; req_wdata = op_wdata[acc];
            end else begin
                req_valid = 1'b0;
            end
            rdy = req_ready;
            tick();
            if (rdy && acc < 7) acc++;
            if (mem_r_enable) n_rd++;
            if (mem_w_enable) n_wr++;
            if (resp_valid) begin
                check($sformatf("b2b%0d_rdata", rsp), resp_rdata, op_exp[rsp]);
                check($sformatf("b2b%0d_err", rsp), {31'b0, resp_err}, 32'd0);
                rsp++;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts",  32'(acc),  32'd7);
        check("b2b_resps",    32'(rsp),  32'd7);
        check("b2b_rd_count", 32'(n_rd), 32'd4);
        check("b2b_wr_count", 32'(n_wr), 32'd3);
        check("b2b_mem_500",  mem[12'h140], 32'h55667788);
        check("b2b_mem_504",  mem[12'h141], 32'h99AABBCC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit that initiates all data-side accesses to the core's word-wide data memory.
- The memory exposes byte address, read enable, write enable and write data, and returns read data one clock after the read enable.
- Takes RV32I load/store requests from the execute stage: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Loads get alignment and sign/zero extension. Sub-word stores become read-modify-write sequences, because the memory only writes whole words.

Parameters:
- MEM_WORDS, 4096, depth of data memory in 32-bit words. Byte addresses >= MEM_WORDS*4 are out of range.
- XLEN, 32, data/address width. Only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data. Low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result. 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3. Valid with resp_valid.
- mem_addr  out  32  word-aligned byte address to memory, bits[1:0] = 0.
- mem_r_enable  out  1  memory read strobe.
- mem_w_enable  out  1  memory write strobe.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word, valid the cycle after mem_r_enable.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state:
  - State is IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_wdata=0, mem_addr=0, mem_r_enable=0, mem_w_enable=0.
  - req_ready=0 while rst is high.
- Accept rule: a request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = (state==IDLE) && !rst.
  - On accept, addr, funct3, we and wdata are registered. The inputs are ignored afterwards.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misalignment:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
- Error path:
  - Misaligned, out-of-range or illegal requests go IDLE -> RESP with resp_err=1.
  - No mem_r_enable or mem_w_enable is ever asserted for them.
- States: IDLE, RD, RD_WAIT, WR, RESP.
  - RD: mem_r_enable=1.
  - RD_WAIT: mem_rdata is valid. It is captured into resp_rdata (load) or merged into the write buffer (sub-word store).
  - WR: mem_w_enable=1, mem_wdata = write buffer.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Memory-side outputs:
  - Decoded from the registered state only.
  - mem_r_enable and mem_w_enable are never high together.
  - mem_addr = {addr_q[31:2],2'b00} in RD and WR, and holds its value otherwise.
- Transitions and latency (accept edge to resp_valid high):
  - Load: IDLE -> RD -> RD_WAIT -> RESP. Latency 3 cycles.
  - SW: IDLE -> WR -> RESP. Latency 2 cycles. The write buffer is loaded with wdata at accept.
  - SB/SH: IDLE -> RD -> RD_WAIT -> WR -> RESP. Latency 4 cycles.
  - Error: IDLE -> RESP. Latency 1 cycle.
- Load extraction:
  - Byte lane = addr[1:0]. Half lane = addr[1].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word.
- Store merge:
  - SB replaces byte addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - All other bytes are kept from mem_rdata.
- resp_rdata and resp_err:
  - Hold their values after RESP until the next RESP.
  - resp_rdata is written to 0 for stores and errors.
- Throughput: back-to-back requests are accepted no earlier than the cycle after RESP, i.e. when IDLE is re-entered.
- Reset mid-operation: the next state is IDLE and all strobes drop the same edge. A pending RMW write is abandoned, so memory is unchanged. No resp_valid is issued for the aborted request.
- Reset in the same cycle as req_valid: the request is not accepted.

Test Plan:
- Preload word at byte 0x40C = 0xFF0F0E0D:
  - LB 0x40F -> resp_rdata 0xFFFFFFFF.
  - LBU 0x40F -> 0x000000FF.
  - LH 0x40E -> 0xFFFFFF0F.
  - LHU 0x40C -> 0x00000E0D.
  - LW 0x40C -> 0xFF0F0E0D.
  - Each load: resp_valid exactly 3 cycles after accept, one mem_r_enable pulse, mem_addr 0x40C.
- Word at 0x400 = 0x04030201, SB 0x401 wdata 0x123456AA:
  - Memory becomes 0x0403AA01.
  - Sequence is mem_r_enable, then mem_w_enable two cycles later with mem_wdata 0x0403AA01.
  - resp_valid 4 cycles after accept. resp_err 0.
- SH 0x402 wdata 0xBEEF over 0x04030201 -> memory 0xBEEF0201. SW 0x404 wdata 0xDEADBEEF -> single mem_w_enable, resp_valid 2 cycles after accept.
- Error requests, each giving resp_err=1 and resp_valid 1 cycle after accept, with no memory strobes:
  - SW 0x402 (misaligned).
  - LH 0x401 (misaligned).
  - LW 0x4000 (out of range, MEM_WORDS=4096).
  - Load funct3 011 (illegal).
- Assert rst in RD_WAIT of SB 0x401 -> next cycle IDLE, mem_w_enable never high, memory still 0x04030201, no resp_valid. After release, req_ready=1.
- Hold req_valid continuously with alternating LW/SW -> each accepted only when req_ready=1. No request is dropped or duplicated. Order is preserved in memory contents.
